// File: rtl/sum_output_stage_n_pkg.sv
`default_nettype none
// ============================================================================
// knowles_pkg : shared constants and types for the Knowles adder output stage
// Revision    : 1.0
// ============================================================================
package knowles_pkg;

  localparam int KNOWLES_WIDTH = 32;

  // Result word at the default adder width.
  typedef struct packed {
    logic [KNOWLES_WIDTH-1:0] sum;
    logic                     cout;
    logic                     ovf;
    logic                     zero;
  } result_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

endpackage : knowles_pkg
`default_nettype wire

// File: rtl/sum_output_stage_n_if.sv
`default_nettype none
// ============================================================================
// sum_output_stage_n_if : operand/result handshake bundle of the output stage
// Revision              : 1.0
// ============================================================================
interface sum_output_stage_n_if
  import knowles_pkg::*;
#(
  parameter int WIDTH = KNOWLES_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] p_n;
  logic [WIDTH-1:0] gc_n;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  // master: the upstream producer plus downstream consumer environment
  modport master (
    output in_valid, p_n, gc_n, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  // slave: the output stage itself
  modport slave (
    input  in_valid, p_n, gc_n, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface : sum_output_stage_n_if
`default_nettype wire

// File: rtl/sum_output_stage_n_output_sum_n.sv
`default_nettype none
// ============================================================================
// output_sum_n : per-bit sum cell, S = P_n ~^ C
// Revision     : 1.0
// ============================================================================
module output_sum_n (
  input  wire logic i_p_n,
  input  wire logic i_c,
  output logic      o_s
);

  assign o_s = i_p_n ~^ i_c;

endmodule : output_sum_n
`default_nettype wire

// File: rtl/sum_output_stage_n.sv
`default_nettype none
// ============================================================================
// sum_output_stage_n : sum/flag formation and 2-entry skid buffer
// Revision           : 1.0
// ============================================================================
module sum_output_stage_n
  import knowles_pkg::*;
#(
  parameter int WIDTH = KNOWLES_WIDTH
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  sum_output_stage_n_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } word_t;

  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  word_t            w_word;
  logic             w_acc;
  logic             w_dlv;

  state_t           r_state;
  word_t            r_main;
  word_t            r_skid;
  logic             r_in_ready;
  logic             r_out_valid;

  // gc_n[i] is the inverted carry out of bit i, hence the carry into bit i+1.
  assign w_carry = {~bus.gc_n[WIDTH-2:0], bus.cin};

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      output_sum_n u_cell (
        .i_p_n (bus.p_n[gi]),
        .i_c   (w_carry[gi]),
        .o_s   (w_sum[gi])
      );
    end
  endgenerate

  always_comb begin
    w_word.sum  = w_sum;
    w_word.cout = ~bus.gc_n[WIDTH-1];
    w_word.ovf  = w_carry[WIDTH-1] ^ ~bus.gc_n[WIDTH-1];
    w_word.zero = ~|w_sum;
  end

  assign w_acc = bus.in_valid & r_in_ready;
  assign w_dlv = r_out_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main      <= w_word;
            r_state     <= ST_ONE;
            r_out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_dlv) begin
            r_main <= w_word;
          end else if (w_acc) begin
            r_skid     <= w_word;
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
          end else if (w_dlv) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (w_dlv) begin
            r_main     <= r_skid;
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_main.sum;
  assign bus.cout      = r_main.cout;
  assign bus.ovf       = r_main.ovf;
  assign bus.zero      = r_main.zero;

endmodule : sum_output_stage_n
`default_nettype wire

// File: tb/tb_sum_output_stage_n.sv
`default_nettype none
// ============================================================================
// tb_sum_output_stage_n : randomized scoreboard bench for the output stage
// Revision              : 1.0
// ============================================================================
module tb_sum_output_stage_n;
  import knowles_pkg::*;

  localparam int W = KNOWLES_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum_output_stage_n_if #(.WIDTH(W)) bus ();

  sum_output_stage_n #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [W+2:0] q[$];
  logic [W+2:0] obs;
  assign obs = {bus.sum, bus.cout, bus.ovf, bus.zero};

  // Behavioural input cells + prefix tree: ripple of generate/propagate.
  function automatic logic [W-1:0] f_gc_n(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    logic [W-1:0] r;
    logic c;
    c = ci;
    for (int i = 0; i < W; i++) begin
      c    = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      r[i] = ~c;
    end
    return r;
  endfunction

  // Reference result from plain arithmetic.
  function automatic logic [W+2:0] f_expect(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    logic [W:0] s;
    logic       v;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {s[W-1:0], s[W], v, (s[W-1:0] == '0)};
  endfunction

  task automatic drive_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    bus.in_valid = 1'b1;
    bus.p_n      = ~(a ^ b);
    bus.gc_n     = f_gc_n(a, b, ci);
    bus.cin      = ci;
  endtask

  task automatic drive_idle();
    bus.in_valid = 1'b0;
    bus.p_n      = W'($urandom);
    bus.gc_n     = W'($urandom);
    bus.cin      = 1'($urandom);
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.out_ready = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL reset_hold: valid=%b ready=%b word=%h, required 0/1/0",
               bus.out_valid, bus.in_ready, obs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL reset_release: valid=%b ready=%b word=%h, required 0/1/0",
               bus.out_valid, bus.in_ready, obs);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[2];
    logic [W-1:0] vb[2];
    logic         vc[2];
    logic [W+2:0] ve[2];
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h0000_0001; vc[0] = 1'b0;
    ve[0] = {32'h8000_0000, 1'b0, 1'b1, 1'b0};
    va[1] = 32'hFFFF_FFFF; vb[1] = 32'h0000_0000; vc[1] = 1'b1;
    ve[1] = {32'h0000_0000, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      drive_beat(va[k], vb[k], vc[k]);
      bus.out_ready = 1'b1;
      @(negedge clk);
      drive_idle();
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== ve[k]) begin
        errors++;
        $display("FAIL directed_%0d: valid=%b word=%h, required 1/%h", k, bus.out_valid, obs, ve[k]);
      end
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL directed_empty_%0d: valid=%b, required 0", k, bus.out_valid);
      end
    end
  endtask

  task automatic test_stream();
    int sent = 0;
    int got  = 0;
    logic [W-1:0] a, b;
    logic ci;
    q.delete();
    for (int c = 0; c < 1005; c++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: got word=%h, required no beat", obs);
        end else begin
          if (obs !== q[0]) begin
            errors++;
            $display("FAIL stream_data: got %h, required %h", obs, q[0]);
          end
          void'(q.pop_front());
          got++;
        end
      end
      if (c >= 1 && c <= 1000) begin
        checks++;
        if (bus.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream_throughput: cycle %0d valid=%b, required 1", c, bus.out_valid);
        end
      end
      if (sent < 1000) begin
        a = $urandom; b = $urandom; ci = 1'($urandom);
        drive_beat(a, b, ci);
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready: cycle %0d ready=%b, required 1", c, bus.in_ready);
        end else begin
          q.push_back(f_expect(a, b, ci));
          sent++;
        end
      end else begin
        drive_idle();
      end
    end
    checks++;
    if (got != 1000 || q.size() != 0) begin
      errors++;
      $display("FAIL stream_count: delivered %0d left %0d, required 1000/0", got, q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a[3], b[3];
    logic         ci[3];
    logic [W+2:0] e[3];
    for (int k = 0; k < 3; k++) begin
      a[k] = $urandom; b[k] = $urandom; ci[k] = 1'($urandom);
      e[k] = f_expect(a[k], b[k], ci[k]);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_beat(a[0], b[0], ci[0]);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || obs !== e[0]) begin
      errors++;
      $display("FAIL bp_first: ready=%b valid=%b word=%h, required 1/1/%h",
               bus.in_ready, bus.out_valid, obs, e[0]);
    end
    drive_beat(a[1], b[1], ci[1]);
    @(negedge clk);
    drive_beat(a[2], b[2], ci[2]);
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs !== e[0]) begin
        errors++;
        $display("FAIL bp_stall_%0d: ready=%b valid=%b word=%h, required 0/1/%h",
                 s, bus.in_ready, bus.out_valid, obs, e[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1 || obs !== e[1]) begin
      errors++;
      $display("FAIL bp_second: ready=%b valid=%b word=%h, required 1/1/%h",
               bus.in_ready, bus.out_valid, obs, e[1]);
    end
    @(negedge clk);
    drive_idle();
    checks++;
    if (bus.out_valid !== 1'b1 || obs !== e[2]) begin
      errors++;
      $display("FAIL bp_third: valid=%b word=%h, required 1/%h", bus.out_valid, obs, e[2]);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    logic         hold = 1'b0;
    logic [W+2:0] prev_word = '0;
    int           acc = 0;
    int           dlv = 0;
    logic [W-1:0] a, b;
    logic         ci;
    q.delete();
    for (int c = 0; c < 10010; c++) begin
      @(negedge clk);
      if (hold) begin
        checks++;
        if (bus.out_valid !== 1'b1 || obs !== prev_word) begin
          errors++;
          $display("FAIL rand_stable: cycle %0d valid=%b word=%h, required 1/%h",
                   c, bus.out_valid, obs, prev_word);
        end
      end
      bus.out_ready = (c >= 10000) ? 1'b1 : 1'($urandom);
      if (c < 10000 && $urandom_range(1, 0) == 1) begin
        a = $urandom; b = $urandom; ci = 1'($urandom);
        drive_beat(a, b, ci);
      end else begin
        drive_idle();
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_extra: cycle %0d word=%h, required no beat", c, obs);
        end else begin
          if (obs !== q[0]) begin
            errors++;
            $display("FAIL rand_data: cycle %0d got %h, required %h", c, obs, q[0]);
          end
          void'(q.pop_front());
          dlv++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(f_expect(a, b, ci));
        acc++;
      end
      hold      = bus.out_valid && !bus.out_ready;
      prev_word = obs;
    end
    checks++;
    if (q.size() != 0 || acc != dlv || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_count: accepted %0d delivered %0d left %0d valid=%b, required equal/0/0",
               acc, dlv, q.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive_beat(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
    @(negedge clk);
    drive_beat(32'hDEAD_BEEF, 32'h0000_0011, 1'b0);
    @(negedge clk);
    drive_idle();
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstfull_fill: ready=%b valid=%b, required 0/1", bus.in_ready, bus.out_valid);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || obs !== '0) begin
      errors++;
      $display("FAIL rstfull_async: valid=%b ready=%b word=%h, required 0/1/0",
               bus.out_valid, bus.in_ready, obs);
    end
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rstfull_after_%0d: valid=%b, required 0", s, bus.out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_random();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sum_output_stage_n
`default_nettype wire
